// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and the fetch-buffer entry type.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~32'h3;
    endfunction
endpackage

// File: rtl/sync_fifo_v.sv
// Single-clock FIFO with flush; head shows the oldest entry, push ignored when full.
module sync_fifo_v #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_push = push && !flush && (count != CW'(DEPTH));
    assign do_pop  = pop  && !flush && (count != '0);
    assign head    = mem[rd_ptr];

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/fetch_v.sv
// Instruction fetch stage: PC ownership, credit-limited imem requests,
// in-order response matching and an output buffer feeding IF/ID.
module fetch_v
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int              MAX_OUTSTANDING = 2,
    parameter int              FIFO_DEPTH      = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            is_stall,
    input  logic            is_redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            is_valid_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] instr_out
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [OW-1:0]   outstanding, kill_cnt, outstanding_after_rsp;
    logic [OW-1:0]   pcq_count;
    logic [XLEN-1:0] pcq_head;
    logic [FW-1:0]   ofifo_count;
    fetch_entry_t    ofifo_head, ofifo_din;
    logic [31:0]     credit_used;
    logic            rsp, accept, killing, pcq_pop, ofifo_push, ofifo_pop;

    // A response with nothing outstanding is spurious and dropped here.
    assign rsp         = imem_rsp_valid && (outstanding != '0);
    assign killing     = (kill_cnt != '0);
    assign credit_used = 32'(outstanding) + 32'(ofifo_count);

    // In-flight requests reserve FIFO slots, so the output FIFO cannot overflow.
    assign imem_req_valid = !reset && !is_redirect
                          && (32'(outstanding) < 32'(MAX_OUTSTANDING))
                          && (credit_used < 32'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // Killed responses belong to requests whose PCs were flushed from the queue.
    assign pcq_pop    = rsp && !killing && (pcq_count != '0);
    assign ofifo_push = rsp && !killing && !is_redirect;
    assign ofifo_din  = '{pc: pcq_head, instr: imem_rsp_data};

    assign is_valid_out = !reset && (ofifo_count != '0);
    assign ofifo_pop    = is_valid_out && !is_stall && !is_redirect;
    assign pc_out       = is_valid_out ? ofifo_head.pc    : '0;
    assign instr_out    = is_valid_out ? ofifo_head.instr : '0;

    assign outstanding_after_rsp = outstanding - OW'(rsp);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            kill_cnt    <= '0;
        end else if (is_redirect) begin
            // Everything still in flight now belongs to the abandoned path.
            fetch_pc    <= word_align(redirect_pc);
            outstanding <= outstanding_after_rsp;
            kill_cnt    <= outstanding_after_rsp;
        end else begin
            if (accept) fetch_pc <= fetch_pc + PC_STEP;
            outstanding <= outstanding_after_rsp + OW'(accept);
            if (rsp && killing) kill_cnt <= kill_cnt - OW'(1);
        end
    end

    sync_fifo_v #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_pcq (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pcq_pop),
        .flush (is_redirect),
        .din   (fetch_pc),
        .count (pcq_count),
        .head  (pcq_head)
    );

    sync_fifo_v #(.WIDTH(2 * XLEN), .DEPTH(FIFO_DEPTH)) u_ofifo (
        .clk   (clk),
        .reset (reset),
        .push  (ofifo_push),
        .pop   (ofifo_pop),
        .flush (is_redirect),
        .din   (ofifo_din),
        .count (ofifo_count),
        .head  (ofifo_head)
    );
endmodule

// File: tb/tb_fetch_v.sv
// Bench for fetch_v: latency-programmable in-order memory plus an expected-PC-stream model.
module tb_fetch_v;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        is_stall = 1'b0;
    logic        is_redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        is_valid_out;
    logic [31:0] pc_out, instr_out;

    int errors = 0;
    int checks = 0;
    int lat = 1;
    int edge_n = 0;
    logic [31:0] exp_pc = '0;

    typedef struct { int due; logic [31:0] addr; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    mreq_t mq[$];
    ent_t  got_q[$];

    fetch_v #(.RESET_PC(32'h0), .MAX_OUTSTANDING(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .is_stall(is_stall), .is_redirect(is_redirect),
        .redirect_pc(redirect_pc), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .is_valid_out(is_valid_out), .pc_out(pc_out), .instr_out(instr_out)
    );

    always #5 clk = ~clk;

    // Memory: mem[a] = a | 0xA000_0000, responses in order, L cycles after acceptance.
    always @(posedge clk) begin
        mreq_t m;
        edge_n++;
        if (reset) mq.delete();
        else begin
            if (imem_rsp_valid && mq.size() > 0) m = mq.pop_front();
            if (imem_req_valid && imem_req_ready)
                mq.push_back('{due: edge_n + lat - 1, addr: imem_req_addr});
        end
        #1;
        if (mq.size() > 0 && mq[0].due <= edge_n) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].addr | 32'hA000_0000;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Record every instruction handed to IF/ID.
    always @(posedge clk) begin
        if (!reset && is_valid_out && !is_stall && !is_redirect)
            got_q.push_back('{pc: pc_out, instr: instr_out});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        tick(); tick(); #1;
        checks++; if (is_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", is_valid_out); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out: got %h want 0", pc_out); end
        checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr_out: got %h want 0", instr_out); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    endtask

    task automatic test_stream();
        int acc = -1, vld = -1;
        ent_t e;
        got_q.delete();
        exp_pc = 32'h0;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (acc < 0 && imem_req_valid && imem_req_ready) acc = c;
            if (vld < 0 && is_valid_out) vld = c;
            if (vld >= 0 && c - vld < 4) begin
                checks++;
                if (pc_out !== 32'(4 * (c - vld)) || instr_out !== (32'(4 * (c - vld)) | 32'hA000_0000)) begin
                    errors++;
                    $display("FAIL stream_seq: pc=%h instr=%h want pc=%h", pc_out, instr_out, 32'(4 * (c - vld)));
                end
            end
            tick();
        end
        checks++;
        if (acc < 0 || vld - acc != 2) begin errors++; $display("FAIL first_latency: accept=%0d valid=%0d want gap 2", acc, vld); end
        while (got_q.size() > 0) begin
            e = got_q.pop_front(); checks++;
            if (e.pc !== exp_pc || e.instr !== (exp_pc | 32'hA000_0000)) begin
                errors++; $display("FAIL stream_order: pc=%h instr=%h want pc=%h", e.pc, e.instr, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_stall();
        ent_t e;
        is_stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (is_valid_out !== 1'b1 || pc_out !== exp_pc) begin
                errors++; $display("FAIL stall_head: valid=%b pc=%h want pc=%h", is_valid_out, pc_out, exp_pc);
            end
            if (i == 5) begin
                checks++;
                if (imem_req_valid !== 1'b0 || dut.ofifo_count !== 3'd4) begin
                    errors++; $display("FAIL stall_full: req_valid=%b count=%0d want 0/4", imem_req_valid, dut.ofifo_count);
                end
            end
            tick();
        end
        is_stall = 1'b0;
        repeat (10) tick();
        while (got_q.size() > 0) begin
            e = got_q.pop_front(); checks++;
            if (e.pc !== exp_pc || e.instr !== (exp_pc | 32'hA000_0000)) begin
                errors++; $display("FAIL stall_resume: pc=%h instr=%h want pc=%h", e.pc, e.instr, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_redirect_kill();
        int found = 0, n = 0;
        ent_t e;
        lat = 3;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (mq.size() == 2) begin found = 1; break; end
            tick();
        end
        checks++; if (found == 0) begin errors++; $display("FAIL kill_setup: outstanding never reached 2"); end
        while (got_q.size() > 0) begin
            e = got_q.pop_front(); checks++;
            if (e.pc !== exp_pc) begin errors++; $display("FAIL kill_pre: pc=%h want %h", e.pc, exp_pc); end
            exp_pc = exp_pc + 32'd4;
        end
        is_redirect = 1'b1; redirect_pc = 32'h0000_0102; exp_pc = 32'h100;
        tick();
        is_redirect = 1'b0;
        #1;
        checks++; if (is_valid_out !== 1'b0) begin errors++; $display("FAIL kill_valid_after: got %b want 0", is_valid_out); end
        checks++; if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL kill_fetch_addr: got %h want 00000100", imem_req_addr); end
        repeat (20) tick();
        while (got_q.size() > 0) begin
            e = got_q.pop_front(); checks++; n++;
            if (e.pc !== exp_pc || e.instr !== (exp_pc | 32'hA000_0000)) begin
                errors++; $display("FAIL kill_post: pc=%h instr=%h want pc=%h", e.pc, e.instr, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
        checks++; if (n < 2) begin errors++; $display("FAIL kill_progress: got %0d entries want >=2", n); end
    endtask

    task automatic test_ready_hold();
        ent_t e;
        lat = 1;
        imem_req_ready = 1'b0;
        repeat (10) tick();
        while (got_q.size() > 0) begin
            e = got_q.pop_front(); checks++;
            if (e.pc !== exp_pc) begin errors++; $display("FAIL hold_drain: pc=%h want %h", e.pc, exp_pc); end
            exp_pc = exp_pc + 32'd4;
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
                errors++; $display("FAIL hold_addr: valid=%b addr=%h want 1/%h", imem_req_valid, imem_req_addr, exp_pc);
            end
            tick();
        end
        imem_req_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin errors++; $display("FAIL hold_accept: addr=%h want %h", imem_req_addr, exp_pc); end
        tick();
        imem_req_ready = 1'b0;
        #1;
        checks++; if (imem_req_addr !== exp_pc + 32'd4) begin errors++; $display("FAIL hold_advance: addr=%h want %h", imem_req_addr, exp_pc + 32'd4); end
        tick();
        imem_req_ready = 1'b1;
        repeat (10) tick();
        while (got_q.size() > 0) begin
            e = got_q.pop_front(); checks++;
            if (e.pc !== exp_pc || e.instr !== (exp_pc | 32'hA000_0000)) begin
                errors++; $display("FAIL hold_stream: pc=%h instr=%h want pc=%h", e.pc, e.instr, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_redirect_same();
        int found = 0, n = 0;
        ent_t e;
        repeat (5) tick();
        for (int c = 0; c < 20; c++) begin
            #1;
            if (is_valid_out && imem_rsp_valid && !is_stall) begin found = 1; break; end
            tick();
        end
        checks++; if (found == 0) begin errors++; $display("FAIL same_setup: no response+pop cycle seen"); end
        while (got_q.size() > 0) begin
            e = got_q.pop_front(); checks++;
            if (e.pc !== exp_pc) begin errors++; $display("FAIL same_pre: pc=%h want %h", e.pc, exp_pc); end
            exp_pc = exp_pc + 32'd4;
        end
        is_redirect = 1'b1; redirect_pc = 32'h0000_0200; exp_pc = 32'h200;
        tick();
        is_redirect = 1'b0;
        repeat (10) tick();
        while (got_q.size() > 0) begin
            e = got_q.pop_front(); checks++; n++;
            if (e.pc !== exp_pc || e.instr !== (exp_pc | 32'hA000_0000)) begin
                errors++; $display("FAIL same_post: pc=%h instr=%h want pc=%h", e.pc, e.instr, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
        checks++; if (n < 1) begin errors++; $display("FAIL same_progress: got %0d entries want >=1", n); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        ent_t e;
        lat = 3; is_stall = 1'b1;
        repeat (3) tick();
        while (got_q.size() > 0) begin
            e = got_q.pop_front(); checks++;
            if (e.pc !== exp_pc) begin errors++; $display("FAIL rmid_pre: pc=%h want %h", e.pc, exp_pc); end
            exp_pc = exp_pc + 32'd4;
        end
        #1;
        checks++; if (!is_valid_out || mq.size() == 0) begin errors++; $display("FAIL rmid_setup: valid=%b inflight=%0d want busy", is_valid_out, mq.size()); end
        reset = 1'b1;
        #1;
        checks++; if (is_valid_out !== 1'b0 || pc_out !== 32'h0) begin errors++; $display("FAIL rmid_during: valid=%b pc=%h want 0/0", is_valid_out, pc_out); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b want 0", imem_req_valid); end
        tick();
        reset = 1'b0; is_stall = 1'b0;
        #1;
        checks++; if (is_valid_out !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", is_valid_out); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL rmid_addr: valid=%b addr=%h want 1/0", imem_req_valid, imem_req_addr); end
        checks++; if (dut.outstanding !== 2'd0) begin errors++; $display("FAIL rmid_outstanding: got %0d want 0", dut.outstanding); end
        exp_pc = 32'h0;
        repeat (15) tick();
        while (got_q.size() > 0) begin
            e = got_q.pop_front(); checks++; n++;
            if (e.pc !== exp_pc || e.instr !== (exp_pc | 32'hA000_0000)) begin
                errors++; $display("FAIL rmid_post: pc=%h instr=%h want pc=%h", e.pc, e.instr, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
        checks++; if (n < 3) begin errors++; $display("FAIL rmid_progress: got %0d entries want >=3", n); end
    endtask

    task automatic test_random();
        int n = 0;
        ent_t e;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) lat = $urandom_range(1, 3);
            imem_req_ready = ($urandom_range(0, 9) < 7);
            is_stall       = ($urandom_range(0, 9) < 3);
            is_redirect    = 1'b0;
            if (c == 200) begin
                is_redirect = 1'b1; redirect_pc = 32'hFFFF_FFF3;
            end else if ($urandom_range(0, 49) == 0) begin
                is_redirect = 1'b1; redirect_pc = $urandom;
            end
            if (is_redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
            #1;
            checks++; if (mq.size() > 2) begin errors++; $display("FAIL rand_outstanding: %0d in flight want <=2", mq.size()); end
            tick();
            while (got_q.size() > 0) begin
                e = got_q.pop_front(); checks++; n++;
                if (e.pc !== exp_pc || e.instr !== (exp_pc | 32'hA000_0000)) begin
                    errors++; $display("FAIL rand_stream: cycle=%0d pc=%h instr=%h want pc=%h", c, e.pc, e.instr, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
            end
        end
        is_redirect = 1'b0; is_stall = 1'b0; imem_req_ready = 1'b1;
        checks++; if (n < 100) begin errors++; $display("FAIL rand_progress: %0d instructions want >=100", n); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_kill();
        test_ready_hold();
        test_redirect_same();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: no finish by time %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
